// File: rtl/csr_defs.sv
// Machine-mode CSR addresses, CSR op encoding and mstatus layout shared by the
// trap/CSR unit and its counters.
package csr_defs;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_t;

  typedef struct packed {
    logic mie;
    logic mpie;
  } mstatus_t;

  // Only M-mode exists, so MPP is hardwired to 2'b11.
  function automatic logic [31:0] mstatus_pack(input mstatus_t s);
    logic [31:0] r;
    r                   = '0;
    r[12:11]            = 2'b11;
    r[MSTATUS_MIE_BIT]  = s.mie;
    r[MSTATUS_MPIE_BIT] = s.mpie;
    return r;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with a write port per 32-bit half; a write to
// either half suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap entry/MRET sequencing and CSR file; issues a handshaked
// PC redirect to ifetch and stalls execute while the redirect is pending.
module trap_csr_unit
  import csr_defs::*;
#(
  parameter int               XLEN    = 32,
  parameter logic [XLEN-1:0]  HART_ID = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_valid,
  input  csr_op_t          csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_wdata,
  input  logic             csr_wsuppress,
  output logic [XLEN-1:0]  csr_rdata,
  output logic             csr_illegal,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_cause,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic [XLEN-1:0]  trap_tval,
  input  logic             mret_valid,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             busy
);

  trap_state_t     state;
  mstatus_t        ms;
  logic [XLEN-1:0] mtvec, mepc, mcause, mtval, mscratch;
  logic [63:0]     mcycle;

  logic [XLEN-1:0] rd_val, wr_val;
  logic            mapped, wants_write, ro_write, bad, csr_we;
  logic            cyc_wr_lo, cyc_wr_hi;

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  rd_val = mstatus_pack(ms);
      CSR_MTVEC:    rd_val = mtvec;
      CSR_MSCRATCH: rd_val = mscratch;
      CSR_MEPC:     rd_val = mepc;
      CSR_MCAUSE:   rd_val = mcause;
      CSR_MTVAL:    rd_val = mtval;
      CSR_MCYCLE:   rd_val = mcycle[31:0];
      CSR_MCYCLEH:  rd_val = mcycle[63:32];
      CSR_MHARTID:  rd_val = HART_ID;
      default:      mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero source field are pure reads and may target read-only space.
  assign wants_write = (csr_op == CSR_OP_RW) || !csr_wsuppress;
  assign ro_write    = (csr_addr[11:10] == 2'b11) && wants_write;
  assign bad         = !mapped || ro_write || (csr_op == CSR_OP_NONE);
  assign csr_illegal = csr_valid && bad;
  assign csr_rdata   = bad ? '0 : rd_val;

  always_comb begin
    case (csr_op)
      CSR_OP_RW: wr_val = csr_wdata;
      CSR_OP_RS: wr_val = rd_val | csr_wdata;
      CSR_OP_RC: wr_val = rd_val & ~csr_wdata;
      default:   wr_val = rd_val;
    endcase
  end

  // A committing trap squashes the CSR write issued alongside it.
  assign csr_we    = csr_valid && !bad && wants_write && (state == ST_IDLE) && !trap_valid;
  assign cyc_wr_lo = csr_we && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = csr_we && (csr_addr == CSR_MCYCLEH);

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (wr_val),
    .count (mcycle)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      ms             <= '0;
      mtvec          <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mscratch       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            ms.mie  <= wr_val[MSTATUS_MIE_BIT];
            ms.mpie <= wr_val[MSTATUS_MPIE_BIT];
          end
          CSR_MTVEC:    mtvec    <= {wr_val[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch <= wr_val;
          CSR_MEPC:     mepc     <= {wr_val[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= wr_val;
          CSR_MTVAL:    mtval    <= wr_val;
          default: ;
        endcase
      end

      // Assignments below follow the CSR write so MRET wins on mstatus.
      case (state)
        ST_IDLE: begin
          if (trap_valid) begin
            mepc           <= {trap_pc[XLEN-1:2], 2'b00};
            mcause         <= trap_cause;
            mtval          <= trap_tval;
            ms.mpie        <= ms.mie;
            ms.mie         <= 1'b0;
            redirect_pc    <= mtvec;
            redirect_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= ST_REDIRECT;
          end else if (mret_valid) begin
            ms.mie         <= ms.mpie;
            ms.mpie        <= 1'b1;
            redirect_pc    <= mepc;
            redirect_valid <= 1'b1;
            busy           <= 1'b1;
            state          <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Upstream must hold off while busy; anything arriving now is dropped.
  a_no_req_in_redirect: assert property (@(posedge clk) disable iff (!rst)
    (state == ST_REDIRECT) |-> !(csr_valid || trap_valid || mret_valid));

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: CSR vector table, directed trap/MRET sequences and
// randomized traffic against an address-keyed reference model.
module tb_trap_csr_unit;
  import csr_defs::*;

  localparam logic [31:0] HART = 32'h5;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid, csr_wsuppress, csr_illegal;
  csr_op_t     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        trap_valid, mret_valid;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        redirect_valid, redirect_ready, busy;
  logic [31:0] redirect_pc;

  trap_csr_unit #(.XLEN(32), .HART_ID(HART)) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wsuppress(csr_wsuppress),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural CSRs keyed by address, plus 64-bit cycle count.
  bit [31:0] mreg [bit [11:0]];
  bit [63:0] m_cycle;
  bit        m_busy;
  bit [31:0] m_rpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [31:0] wmask(input bit [11:0] a);
    case (a)
      12'h300:                   return 32'h0000_0088;
      12'h305, 12'h341:          return 32'hFFFF_FFFC;
      12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
      default:                   return 32'h0;
    endcase
  endfunction

  function automatic bit is_mapped(input bit [11:0] a);
    return mreg.exists(a) || a == 12'hB00 || a == 12'hB80;
  endfunction

  function automatic bit [31:0] m_read(input bit [11:0] a);
    if (a == 12'hB00) return m_cycle[31:0];
    if (a == 12'hB80) return m_cycle[63:32];
    if (mreg.exists(a)) return mreg[a];
    return 32'h0;
  endfunction

  function automatic void model_reset();
    mreg.delete();
    mreg[12'h300] = 32'h1800;
    mreg[12'h305] = 0; mreg[12'h340] = 0; mreg[12'h341] = 0;
    mreg[12'h342] = 0; mreg[12'h343] = 0;
    mreg[12'hF14] = HART;
    m_cycle = 0; m_busy = 0; m_rpc = 0;
  endfunction

  task automatic clear_inputs();
    csr_valid = 0; csr_op = CSR_OP_NONE; csr_addr = 0; csr_wdata = 0; csr_wsuppress = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    mret_valid = 0; redirect_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    @(posedge clk); #1;
    model_reset();
    chk("reset_redirect_valid", {31'b0, redirect_valid}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    rst = 1;
  endtask

  // One clock: drive, check combinational read path, step model, check registered outputs.
  task automatic do_cycle(input bit cv, input bit [1:0] op, input bit [11:0] a,
                          input bit [31:0] wd, input bit ws, input bit tv,
                          input bit [31:0] tc, input bit [31:0] tp, input bit [31:0] tt,
                          input bit mv, input bit rr,
                          output bit [31:0] rd_o, output bit ill_o);
    bit [31:0] old, nv, old_ms, old_mtvec, old_mepc, exp_rd;
    bit        wr, bad, exp_ill, cyc_wr;
    csr_valid = cv; csr_op = csr_op_t'(op); csr_addr = a; csr_wdata = wd; csr_wsuppress = ws;
    trap_valid = tv; trap_cause = tc; trap_pc = tp; trap_tval = tt;
    mret_valid = mv; redirect_ready = rr;
    #2;
    wr      = (op == 2'd1) || !ws;
    bad     = !is_mapped(a) || (a[11:10] == 2'b11 && wr) || op == 2'd0;
    old     = m_read(a);
    exp_ill = cv && bad;
    exp_rd  = bad ? 32'h0 : old;
    rd_o = csr_rdata; ill_o = csr_illegal;
    chk("csr_rdata", rd_o, exp_rd);
    chk("csr_illegal", {31'b0, ill_o}, {31'b0, exp_ill});

    old_ms = mreg[12'h300]; old_mtvec = mreg[12'h305]; old_mepc = mreg[12'h341];
    cyc_wr = 0;
    if (cv && !m_busy && !bad && wr && !tv) begin
      nv = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
      if (a == 12'hB00) begin m_cycle[31:0] = nv; cyc_wr = 1; end
      else if (a == 12'hB80) begin m_cycle[63:32] = nv; cyc_wr = 1; end
      else mreg[a] = (nv & wmask(a)) | (a == 12'h300 ? 32'h1800 : 32'h0);
    end
    if (!cyc_wr) m_cycle = m_cycle + 1;
    if (!m_busy) begin
      if (tv) begin
        mreg[12'h341] = tp & ~32'h3;
        mreg[12'h342] = tc;
        mreg[12'h343] = tt;
        mreg[12'h300] = 32'h1800 | (old_ms[3] ? 32'h80 : 32'h0);
        m_rpc = old_mtvec; m_busy = 1;
      end else if (mv) begin
        mreg[12'h300] = 32'h1880 | (old_ms[7] ? 32'h8 : 32'h0);
        m_rpc = old_mepc; m_busy = 1;
      end
    end else if (rr) begin
      m_busy = 0;
    end

    @(posedge clk); #1;
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_busy});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("redirect_pc", redirect_pc, m_rpc);
    clear_inputs();
  endtask

  task automatic csr(input bit [1:0] op, input bit [11:0] a, input bit [31:0] wd,
                     input bit ws, output bit [31:0] v);
    bit ill;
    do_cycle(1, op, a, wd, ws, 0, 0, 0, 0, 0, 0, v, ill);
  endtask

  task automatic rd(input bit [11:0] a, output bit [31:0] v);
    csr(2'd2, a, 0, 1, v);
  endtask

  task automatic trap(input bit [31:0] tc, input bit [31:0] tp, input bit [31:0] tt);
    bit [31:0] v; bit ill;
    do_cycle(0, 0, 0, 0, 0, 1, tc, tp, tt, 0, 0, v, ill);
  endtask

  task automatic idle(input bit rr);
    bit [31:0] v; bit ill;
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rr, v, ill);
  endtask

  typedef struct {
    bit [1:0]  op;
    bit [11:0] a;
    bit [31:0] wd;
    bit        ws;
    bit [31:0] e_rd;
    bit        e_ill;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t      tbl[$];
    bit [31:0] v, r;
    bit        ill;
    bit [11:0] pool [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'hB00, 12'hB80, 12'hF14, 12'h7C0, 12'hF15, 12'h301};

    // Sequential vectors from reset; each expectation reflects earlier rows.
    tbl.push_back('{2'd2, 12'hF14, 32'h0,          1'b1, HART,           1'b0});
    tbl.push_back('{2'd1, 12'hF14, 32'h1,          1'b0, 32'h0,          1'b1});
    tbl.push_back('{2'd2, 12'h7C0, 32'h0,          1'b1, 32'h0,          1'b1});
    tbl.push_back('{2'd0, 12'h340, 32'h0,          1'b0, 32'h0,          1'b1});
    tbl.push_back('{2'd2, 12'h300, 32'h0,          1'b1, 32'h1800,       1'b0});
    tbl.push_back('{2'd1, 12'h305, 32'hD,          1'b0, 32'h0,          1'b0});
    tbl.push_back('{2'd2, 12'h305, 32'h0,          1'b1, 32'hC,          1'b0});
    tbl.push_back('{2'd1, 12'h340, 32'h12345678,   1'b0, 32'h0,          1'b0});
    tbl.push_back('{2'd3, 12'h340, 32'hFF,         1'b0, 32'h12345678,   1'b0});
    tbl.push_back('{2'd2, 12'h340, 32'hFFFFFFFF,   1'b1, 32'h12345600,   1'b0});
    tbl.push_back('{2'd2, 12'h340, 32'h1,          1'b0, 32'h12345600,   1'b0});
    tbl.push_back('{2'd1, 12'h340, 32'h0,          1'b0, 32'h12345601,   1'b0});
    tbl.push_back('{2'd1, 12'h341, 32'hFFFFFFFF,   1'b0, 32'h0,          1'b0});
    tbl.push_back('{2'd2, 12'h341, 32'h0,          1'b1, 32'hFFFFFFFC,   1'b0});
    tbl.push_back('{2'd1, 12'h300, 32'hFFFFFFFF,   1'b0, 32'h1800,       1'b0});
    tbl.push_back('{2'd3, 12'h300, 32'h8,          1'b0, 32'h1888,       1'b0});
    tbl.push_back('{2'd2, 12'h300, 32'h0,          1'b1, 32'h1880,       1'b0});
    tbl.push_back('{2'd1, 12'h342, 32'hDEAD,       1'b0, 32'h0,          1'b0});
    tbl.push_back('{2'd2, 12'h342, 32'h0,          1'b1, 32'hDEAD,       1'b0});
    tbl.push_back('{2'd1, 12'h343, 32'hBEEF,       1'b0, 32'h0,          1'b0});
    tbl.push_back('{2'd2, 12'h343, 32'h0,          1'b1, 32'hBEEF,       1'b0});
    tbl.push_back('{2'd3, 12'hF14, 32'h0,          1'b1, HART,           1'b0});
    tbl.push_back('{2'd2, 12'hF14, 32'h0,          1'b0, 32'h0,          1'b1});

    clear_inputs();
    rst = 0;
    do_reset();
    rd(12'h300, v); chk("reset_mstatus", v, 32'h1800);

    foreach (tbl[i]) begin
      do_cycle(1, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].ws, 0, 0, 0, 0, 0, 0, r, ill);
      chk($sformatf("tbl%0d_rdata", i), r, tbl[i].e_rd);
      chk($sformatf("tbl%0d_illegal", i), {31'b0, ill}, {31'b0, tbl[i].e_ill});
    end

    // ECALL through mtvec written with low bits set.
    csr(2'd1, 12'h305, 32'hD, 0, v);
    trap(32'd11, 32'h4, 32'h0);
    chk("ecall_rv", {31'b0, redirect_valid}, 1);
    chk("ecall_rpc", redirect_pc, 32'hC);
    idle(1);
    chk("ecall_rv_drop", {31'b0, redirect_valid}, 0);
    rd(12'h341, v); chk("ecall_mepc", v, 32'h4);
    rd(12'h342, v); chk("ecall_mcause", v, 32'd11);
    rd(12'h343, v); chk("ecall_mtval", v, 32'h0);

    // EBREAK with ifetch stalling the redirect.
    trap(32'd3, 32'h1C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("ebreak_hold_rv", {31'b0, redirect_valid}, 1);
      chk("ebreak_hold_pc", redirect_pc, 32'hC);
      chk("ebreak_hold_busy", {31'b0, busy}, 1);
      if (i < 3) idle(0);
    end
    idle(1);
    chk("ebreak_release", {31'b0, busy}, 0);
    rd(12'h341, v); chk("ebreak_mepc", v, 32'h1C);
    rd(12'h342, v); chk("ebreak_mcause", v, 32'd3);

    // MIE/MPIE stacking through trap and MRET.
    csr(2'd2, 12'h300, 32'h8, 0, v);
    trap(32'd11, 32'h40, 32'h0);
    idle(1);
    rd(12'h300, v); chk("trap_mstatus", v, 32'h1880);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, v, ill);
    chk("mret_rv", {31'b0, redirect_valid}, 1);
    chk("mret_rpc", redirect_pc, 32'h40);
    idle(1);
    rd(12'h300, v); chk("mret_mstatus", v, 32'h1888);

    // Trap squashes a same-cycle CSR write.
    csr(2'd1, 12'h340, 32'h0, 0, v);
    do_cycle(1, 2'd1, 12'h340, 32'h55, 0, 1, 32'd2, 32'h103, 32'hBAD, 0, 0, v, ill);
    idle(1);
    rd(12'h340, v); chk("squash_mscratch", v, 32'h0);
    rd(12'h341, v); chk("squash_mepc", v, 32'h100);
    rd(12'h342, v); chk("squash_mcause", v, 32'd2);
    rd(12'h343, v); chk("squash_mtval", v, 32'hBAD);

    // 64-bit wrap of mcycle.
    csr(2'd1, 12'hB00, 32'hFFFFFFFF, 0, v);
    csr(2'd1, 12'hB80, 32'hFFFFFFFF, 0, v);
    idle(0);
    rd(12'hB80, v); chk("wrap_mcycleh", v, 32'h0);
    rd(12'hB00, v); chk("wrap_mcycle", v, 32'h1);

    // Reset while a redirect is pending.
    csr(2'd1, 12'h305, 32'h200, 0, v);
    trap(32'd5, 32'h80, 32'h99);
    chk("pre_reset_busy", {31'b0, busy}, 1);
    do_reset();
    rd(12'h305, v); chk("post_reset_mtvec", v, 32'h0);

    // Randomized traffic; no requests are issued while a redirect is pending.
    for (int n = 0; n < 400; n++) begin
      if (m_busy) begin
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), v, ill);
      end else begin
        int ev;
        ev = $urandom_range(0, 15);
        do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 pool[$urandom_range(0, 11)], $urandom, 1'($urandom_range(0, 1)),
                 ev == 0 || ev == 2, $urandom, $urandom, $urandom,
                 ev == 1 || ev == 2 || ev == 3, 1'($urandom_range(0, 1)), v, ill);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
